mmult_accel_mac_pipe: RTL and testbench
=======================================

# mmult_accel_mac_pipe

Parametrised pipelined multiply-accumulate unit for the matmul accelerator datapath: the successor to the fixed-width unsigned 5-stage multiplier. It adds configurable operand widths and multiplier depth, per-beat signed/unsigned mode, valid tracking through the pipe, and grouped accumulation that emits one dot-product result per group with an overflow flag. It sits between the operand fetch stage and the output tile buffer, and inherits the codebase's global `ce` stall.

## Interface
- `DIN0_WIDTH`, default 31: width of operand A.
- `DIN1_WIDTH`, default 31: width of operand B.
- `ACC_WIDTH`, default 72: accumulator and result width. Must be ≥ DIN0_WIDTH+DIN1_WIDTH.
- `MUL_STAGES`, default 4: multiplier register stages, counting the operand input register. Must be ≥ 1.
- `clk` in 1: clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `ce` in 1: clock enable. When low, every register holds, including valid bits and outputs.
- `in_valid` in 1: the beat is present.
- `in_first` in 1: the beat opens a new group.
- `in_last` in 1: the beat closes the group.
- `din_signed` in 1: 1 means operands are two's complement; 0 means unsigned.
- `din0` in DIN0_WIDTH: operand A.
- `din1` in DIN1_WIDTH: operand B.
- `out_valid` out 1: a group result is present.
- `out_data` out ACC_WIDTH: group sum, wrapped modulo 2^ACC_WIDTH.
- `out_overflow` out 1: the group overflowed, qualified by `out_valid`.

## Operation
- A beat is accepted on a rising edge with `ce`=1 and `in_valid`=1. Edges with `ce`=1 and `in_valid`=0 insert a bubble.
- Sideband travels with its beat through all stages: valid, first, last and signed.
- **Multiplier**
  - In signed mode, operands are sign-extended by 1 bit. In unsigned mode they are zero-extended by 1 bit.
  - The product is DIN0_WIDTH+DIN1_WIDTH bits and is exact in both modes.
  - The product is extended to ACC_WIDTH per the beat's mode: sign extension if signed, zero extension if unsigned.
- **Accumulator state**
  - `acc` is ACC_WIDTH bits, `open` is 1 bit, `ovf` is a sticky bit.
  - When a product arrives with first=1, or with open=0: `acc`=P, `ovf`=0, `open`=1.
  - Otherwise: `acc`=`acc`+P, wrapping. `ovf` is set on overflow.
  - Signed overflow: the addends have equal sign bits and the sum's sign differs. Unsigned overflow: carry out of bit ACC_WIDTH-1. Each beat uses its own mode.
  - `din_signed` must be constant within a group. A mixed group yields an undefined `out_overflow` but is still summed.
- **Last beat** (product arrives with last=1): on the same edge, `out_data` = the updated `acc`, `out_overflow` = the updated `ovf`, `out_valid`=1, `open`=0.
- A single-beat group (first=1 and last=1) outputs P.
- A new group's first beat may immediately follow a last beat. No bubble is required and no cycle is lost.
- `out_data` and `out_overflow` hold their values until the next result.
- **Reset**: on an edge with `reset`=1, regardless of `ce`:
  - All pipeline valid bits, `acc`, `open`, `ovf`, `out_valid`, `out_data` and `out_overflow` clear to 0.
  - In-flight beats are discarded and no result is produced for them.
  - Operand and product registers also clear to 0.

## Timing
- Latency: a last beat accepted at ce-edge k produces `out_valid`=1 after ce-edge k+MUL_STAGES. That is MUL_STAGES+1 ce-enabled edges, 5 at the defaults.
- Throughput: one beat per ce-enabled cycle. No backpressure.
- `out_valid` is a one-ce-cycle pulse. It clears on the next ce-enabled edge unless another result completes on that edge.
- While `ce`=0, `out_valid` holds its value. Consumers qualify with `ce`.
- A `ce` stall of n cycles delays the result by exactly n cycles without changing its value.
- Reset has priority over `ce`. The first beat after reset can be accepted on the first edge with `reset`=0.

## Test plan
- **Single beat**: unsigned, first=1, last=1, din0=3, din1=5 → `out_valid` pulses 5 ce-edges later with `out_data`=15 and `out_overflow`=0.
- **Back-to-back signed groups**:
  - Group 1 is (-2,3), (7,7), (-1,-1), (0,9).
  - Group 2 starts on the next cycle with (4,4) as first=1, last=1.
  - → Results 44 then 16 on consecutive cycles, `out_overflow`=0 for both.
- **Stall**: the same 4-beat group with `ce` low for 3 cycles after beat 2 → `out_data`=44 arrives 3 cycles later than without the stall, and `out_valid` is held through any stall that overlaps it.
- **Overflow** (ACC_WIDTH=62): two unsigned beats of 0x7FFFFFFF×0x7FFFFFFF → `out_data`=0x3FFFFFFE00000002 and `out_overflow`=1.
- **Reset mid-group**: two beats are accepted, then `reset` is high for 1 cycle, then a single beat (2,2) first=1, last=1 → exactly one `out_valid` with `out_data`=4. There is no output from the pre-reset beats.
- **Orphan and gaps**:
  - A non-first beat (5,5) arrives with no group open, then bubbles, then (1,1) with last=1.
  - → The orphan opens a group and the result is 26.
  - → Bubbles do not affect the sum.

Source files
------------

// File: rtl/mmult_accel_mac_pipe.sv
// Pipelined signed/unsigned multiply-accumulate with grouped dot-product output.
// Operand register, MUL_STAGES-1 product registers, then the accumulator/output stage.
module mmult_accel_mac_pipe #(
  parameter int DIN0_WIDTH = 31,
  parameter int DIN1_WIDTH = 31,
  parameter int ACC_WIDTH  = 72,
  parameter int MUL_STAGES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_last,
  input  logic                  din_signed,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  output logic                  out_valid,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic                  out_overflow
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
    logic sgn;
  } side_t;

  side_t                 op_side;
  logic [DIN0_WIDTH:0]   a_q;
  logic [DIN1_WIDTH:0]   b_q;
  logic signed [PW-1:0]  a_w;
  logic signed [PW-1:0]  b_w;
  logic signed [PW-1:0]  prod_comb;
  logic [PW-1:0]         p;
  side_t                 ps;

  // NOTE: sequential state always uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_side <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else if (ce) begin
      op_side <= '{valid: in_valid, first: in_first, last: in_last, sgn: din_signed};
      a_q     <= {din_signed & din0[DIN0_WIDTH-1], din0};
      b_q     <= {din_signed & din1[DIN1_WIDTH-1], din1};
    end
  end

  // One extra operand bit makes a single signed multiply exact for both modes;
  // the low PW bits of the product are the full result.
  assign a_w       = PW'($signed(a_q));
  assign b_w       = PW'($signed(b_q));
  assign prod_comb = a_w * b_w;

  if (MUL_STAGES > 1) begin : g_pipe
    localparam int D = MUL_STAGES - 1;
    logic [PW-1:0] prod_q [D];
    side_t         side_q [D];

    // NOTE: the product pipe is a register array, not a RAM, so clearing it in a
    // reset loop is legal and is what discards in-flight beats.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < D; i++) begin
          prod_q[i] <= '0;
          side_q[i] <= '0;
        end
      end else if (ce) begin
        prod_q[0] <= prod_comb;
        side_q[0] <= op_side;
        for (int i = 1; i < D; i++) begin
          prod_q[i] <= prod_q[i-1];
          side_q[i] <= side_q[i-1];
        end
      end
    end

    assign p  = prod_q[D-1];
    assign ps = side_q[D-1];
  end else begin : g_comb
    assign p  = prod_comb;
    assign ps = op_side;
  end

  logic [ACC_WIDTH-1:0] acc_q;
  logic                 open_q;
  logic                 ovf_q;
  logic [ACC_WIDTH-1:0] p_ext;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH-1:0] acc_nxt;
  logic                 start;
  logic                 beat_ovf;
  logic                 ovf_nxt;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    p_ext    = ps.sgn ? ACC_WIDTH'($signed(p)) : ACC_WIDTH'(p);
    sum      = {1'b0, acc_q} + {1'b0, p_ext};
    start    = ps.first | ~open_q;
    beat_ovf = ps.sgn ? ((acc_q[ACC_WIDTH-1] == p_ext[ACC_WIDTH-1]) &&
                         (sum[ACC_WIDTH-1] != acc_q[ACC_WIDTH-1]))
                      : sum[ACC_WIDTH];
    acc_nxt  = start ? p_ext : sum[ACC_WIDTH-1:0];
    ovf_nxt  = start ? 1'b0 : (ovf_q | beat_ovf);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q        <= '0;
      open_q       <= 1'b0;
      ovf_q        <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_overflow <= 1'b0;
    end else if (ce) begin
      out_valid <= ps.valid & ps.last;
      if (ps.valid) begin
        acc_q  <= acc_nxt;
        ovf_q  <= ovf_nxt;
        open_q <= ~ps.last;
        if (ps.last) begin
          out_data     <= acc_nxt;
          out_overflow <= ovf_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmult_accel_mac_pipe.sv
// Directed bench for mmult_accel_mac_pipe: default instance plus a 62-bit
// accumulator instance sharing the same stimulus for the overflow case.
module tb_mmult_accel_mac_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        din_signed = 1'b0;
  logic [30:0] din0 = '0;
  logic [30:0] din1 = '0;
  logic        out_valid;
  logic [71:0] out_data;
  logic        out_overflow;
  logic        out_valid62;
  logic [61:0] out_data62;
  logic        out_overflow62;

  mmult_accel_mac_pipe dut (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din_signed(din_signed), .din0(din0), .din1(din1),
    .out_valid(out_valid), .out_data(out_data), .out_overflow(out_overflow)
  );

  mmult_accel_mac_pipe #(.ACC_WIDTH(62)) dut62 (
    .clk(clk), .reset(reset), .ce(ce), .in_valid(in_valid), .in_first(in_first),
    .in_last(in_last), .din_signed(din_signed), .din0(din0), .din1(din1),
    .out_valid(out_valid62), .out_data(out_data62), .out_overflow(out_overflow62)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] data;
    logic        ovf;
    int          edge_n;
    int          cyc;
  } res_t;

  res_t q[$];
  res_t q62[$];
  res_t r;
  int   edge_cnt = 0;
  int   cyc = 0;
  logic last_ce = 1'b0;
  int   vectors = 0;
  int   errors = 0;

  // Count clock cycles and ce-enabled edges; log each fresh result once.
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    last_ce <= ce && !reset;
    if (ce && !reset) edge_cnt <= edge_cnt + 1;
  end

  always @(negedge clk) begin
    if (last_ce && out_valid)   q.push_back('{out_data, out_overflow, edge_cnt, cyc});
    if (last_ce && out_valid62) q62.push_back('{72'(out_data62), out_overflow62, edge_cnt, cyc});
  end

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic take(input string tag, input bit from62);
    vectors++;
    if (from62) begin
      assert (q62.size() > 0) else begin
        errors++;
        $error("FAIL %s observed=no result expected=result", tag);
      end
      r = (q62.size() > 0) ? q62.pop_front() : '{default: '0};
    end else begin
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL %s observed=no result expected=result", tag);
      end
      r = (q.size() > 0) ? q.pop_front() : '{default: '0};
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic f, input logic l, input logic s,
                      input logic [30:0] a, input logic [30:0] b);
    in_valid   = 1'b1;
    in_first   = f;
    in_last    = l;
    din_signed = s;
    din0       = a;
    din1       = b;
    tick();
    in_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  int k;
  int c0;

  initial begin
    // Reset state
    repeat (2) tick();
    @(negedge clk);
    chk("reset_out_valid", 72'(out_valid), 72'd0);
    chk("reset_out_data", out_data, 72'd0);
    chk("reset_out_overflow", 72'(out_overflow), 72'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Single unsigned beat 3*5, latency 4 ce-edges after acceptance
    q.delete();
    beat(1, 1, 0, 31'd3, 31'd5);
    k = edge_cnt;
    idle(7);
    chk("single_count", 72'(q.size()), 72'd1);
    take("single_present", 0);
    chk("single_data", r.data, 72'd15);
    chk("single_ovf", 72'(r.ovf), 72'd0);
    chk("single_latency", 72'(r.edge_n), 72'(k + 4));

    // Back-to-back signed groups: 44 then 16 on consecutive edges
    q.delete();
    beat(1, 0, 1, 31'(-2), 31'd3);
    beat(0, 0, 1, 31'd7, 31'd7);
    beat(0, 0, 1, 31'(-1), 31'(-1));
    beat(0, 1, 1, 31'd0, 31'd9);
    k = edge_cnt;
    beat(1, 1, 1, 31'd4, 31'd4);
    idle(7);
    chk("b2b_count", 72'(q.size()), 72'd2);
    take("b2b_g1_present", 0);
    chk("b2b_g1_data", r.data, 72'd44);
    chk("b2b_g1_ovf", 72'(r.ovf), 72'd0);
    chk("b2b_g1_edge", 72'(r.edge_n), 72'(k + 4));
    take("b2b_g2_present", 0);
    chk("b2b_g2_data", r.data, 72'd16);
    chk("b2b_g2_ovf", 72'(r.ovf), 72'd0);
    chk("b2b_g2_edge", 72'(r.edge_n), 72'(k + 5));

    // Stall of 3 cycles after beat 2, then a stall overlapping the result
    q.delete();
    beat(1, 0, 1, 31'(-2), 31'd3);
    c0 = cyc;
    beat(0, 0, 1, 31'd7, 31'd7);
    ce = 1'b0;
    repeat (3) tick();
    ce = 1'b1;
    beat(0, 0, 1, 31'(-1), 31'(-1));
    beat(0, 1, 1, 31'd0, 31'd9);
    k = edge_cnt;
    idle(4);
    chk("stall_valid_rise", 72'(out_valid), 72'd1);
    ce = 1'b0;
    @(negedge clk);
    chk("stall_valid_held1", 72'(out_valid), 72'd1);
    tick();
    @(negedge clk);
    chk("stall_valid_held2", 72'(out_valid), 72'd1);
    chk("stall_data_held", out_data, 72'd44);
    #4;
    ce = 1'b1;
    tick();
    chk("stall_valid_drop", 72'(out_valid), 72'd0);
    idle(2);
    chk("stall_count", 72'(q.size()), 72'd1);
    take("stall_present", 0);
    chk("stall_data", r.data, 72'd44);
    chk("stall_cycle", 72'(r.cyc), 72'(c0 + 10));
    chk("stall_edge", 72'(r.edge_n), 72'(k + 4));

    // Unsigned overflow at 62-bit accumulator; 72-bit instance does not overflow
    q.delete();
    q62.delete();
    beat(1, 0, 0, 31'h7FFFFFFF, 31'h7FFFFFFF);
    beat(0, 1, 0, 31'h7FFFFFFF, 31'h7FFFFFFF);
    idle(7);
    take("ovf62_present", 1);
    chk("ovf62_data", r.data, 72'h3FFFFFFE00000002);
    chk("ovf62_flag", 72'(r.ovf), 72'd1);
    take("ovf72_present", 0);
    chk("ovf72_data", r.data, 72'h7FFFFFFE00000002);
    chk("ovf72_flag", 72'(r.ovf), 72'd0);

    // Reset mid-group discards in-flight beats
    q.delete();
    beat(1, 0, 0, 31'd9, 31'd9);
    beat(0, 1, 0, 31'd9, 31'd9);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    beat(1, 1, 0, 31'd2, 31'd2);
    idle(8);
    chk("rst_count", 72'(q.size()), 72'd1);
    take("rst_present", 0);
    chk("rst_data", r.data, 72'd4);

    // Orphan beat opens a group; bubbles do not disturb the sum
    q.delete();
    beat(0, 0, 0, 31'd5, 31'd5);
    idle(3);
    beat(0, 1, 0, 31'd1, 31'd1);
    idle(7);
    chk("orphan_count", 72'(q.size()), 72'd1);
    take("orphan_present", 0);
    chk("orphan_data", r.data, 72'd26);
    chk("orphan_ovf", 72'(r.ovf), 72'd0);

    // Mode-dependent extension: all-ones operand as unsigned vs signed
    q.delete();
    beat(1, 1, 0, 31'h7FFFFFFF, 31'd2);
    beat(1, 1, 1, 31'h7FFFFFFF, 31'd2);
    idle(7);
    take("mode_u_present", 0);
    chk("mode_u_data", r.data, 72'hFFFFFFFE);
    take("mode_s_present", 0);
    chk("mode_s_data", r.data, 72'hFFFFFFFFFFFFFFFFFE);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
